mem_stage: RTL and testbench

- Memory stage of the five-stage RV32I pipeline, directly downstream of the execute stage.
- Consumes the execute→memory pipeline register contents and runs loads/stores on a req/ready data-memory bus.
- Stalls upstream while the bus is busy, resolves branch redirects, and registers results into the memory→writeback pipeline register.

---
 rtl/mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of a five-stage RV32I pipeline.
//
// Takes the execute->memory register contents, runs loads/stores on a simple
// req/ready data bus, holds the upstream pipeline while the bus is busy,
// resolves branch redirects and registers the result into the
// memory->writeback register.
//
// Build option: MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses are not issued; bus_errM pulses and
//               the instruction retires as a bubble.
//   undefined - no alignment check; low address bits only steer lanes/strobes.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   strCtrlM .. r2M          execute->memory register fields
//   PCSrcM, PCTargetM        fetch redirect
//   stallM                   freezes fetch/decode/execute and the M inputs
//   dmem_*                   data-memory bus (word address, byte strobes)
//   bus_errM                 one-cycle pulse on timeout or misalignment
//   RegWriteW .. rdW         memory->writeback register
//
// State table:
//   S_IDLE | no access outstanding; a ready access completes here
//   S_WAIT | access issued, waiting for dmem_ready; counts wait cycles
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  strCtrlM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        PCBranchM,
  input  logic        branchM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] PCplusImmM,
  input  logic [4:0]  rdM,
  input  logic [31:0] r2M,
  output logic        PCSrcM,
  output logic [31:0] PCTargetM,
  output logic        stallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        bus_errM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ALUoutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  rdW
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        memop, misalign, issue, abort;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign memop = MemWriteM | MemtoRegM;

`ifdef MISALIGN_TRAP_EN
  assign misalign = memop & (((strCtrlM[1:0] == 2'b01) & ALUoutM[0]) |
                             ((strCtrlM[1:0] == 2'b10) & (|ALUoutM[1:0])));
`else
  assign misalign = 1'b0;
`endif

  assign issue = memop & ~misalign;

  // Store lane steering
  always_comb begin
    strb  = 4'b0000;
    wdata = r2M;
    case (strCtrlM[1:0])
      2'b00: begin
        strb  = 4'b0001 << ALUoutM[1:0];
        wdata = {4{r2M[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << {ALUoutM[1], 1'b0};
        wdata = {2{r2M[15:0]}};
      end
      2'b10: begin
        strb  = 4'b1111;
        wdata = r2M;
      end
      default: begin
        strb  = 4'b0000;
        wdata = r2M;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (ALUoutM[1:0])
      2'b00: byte_sel = dmem_rdata[7:0];
      2'b01: byte_sel = dmem_rdata[15:8];
      2'b10: byte_sel = dmem_rdata[23:16];
      2'b11: byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel = ALUoutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (strCtrlM)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'b0, byte_sel};
      3'b101:  load_data = {16'b0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue && !dmem_ready) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 8'd1;
        end
      end
      S_WAIT: begin
        // Upstream holds the M inputs while stalled; a dropped request
        // simply returns to idle.
        if (!issue || dmem_ready) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
        end else if (cnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Control outputs are gated by rst so they drop the moment reset asserts.
  assign dmem_req   = issue & rst;
  assign stallM     = issue & ~dmem_ready & ~abort & rst;
  assign bus_errM   = (abort | misalign) & rst;
  assign PCSrcM     = PCBranchM & branchM & ~stallM & rst;
  assign PCTargetM  = PCplusImmM;
  assign dmem_addr  = {ALUoutM[31:2], 2'b00};
  assign dmem_we    = MemWriteM;
  assign dmem_wdata = wdata;
  assign dmem_wstrb = MemWriteM ? strb : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ALUoutW   <= 32'd0;
      ReadDataW <= 32'd0;
      rdW       <= 5'd0;
    end else if (stallM || bus_errM) begin
      // Bubble: kill the write, keep the data fields as they were.
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      ALUoutW   <= ALUoutM;
      rdW       <= rdM;
      ReadDataW <= MemtoRegM ? load_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  strCtrlM;
  logic        RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM;
  logic [31:0] ALUoutM, PCplusImmM, r2M;
  logic [4:0]  rdM;
  logic        PCSrcM, stallM, dmem_req, dmem_we, bus_errM;
  logic [31:0] PCTargetM, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        RegWriteW, MemtoRegW;
  logic [31:0] ALUoutW, ReadDataW;
  logic [4:0]  rdW;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .strCtrlM(strCtrlM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCBranchM(PCBranchM),
    .branchM(branchM), .ALUoutM(ALUoutM), .PCplusImmM(PCplusImmM), .rdM(rdM),
    .r2M(r2M), .PCSrcM(PCSrcM), .PCTargetM(PCTargetM), .stallM(stallM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .bus_errM(bus_errM), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .ALUoutW(ALUoutW), .ReadDataW(ReadDataW), .rdW(rdW)
  );

  // ---------------- behavioural model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int acc_base(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return int'(a[1:0]);
      2'b01:   return 2 * int'(a[1]);
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = acc_size(f3);
    if (sz == 0 || sz == 4) return rd;
    v = (rd >> (8 * acc_base(f3, a))) & ((32'd1 << (8 * sz)) - 32'd1);
    if (!f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int sz, b;
    s  = 4'b0;
    sz = acc_size(f3);
    b  = acc_base(f3, a);
    for (int i = 0; i < 4; i++) if (i >= b && i < b + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] r2);
    logic [31:0] v;
    int sz;
    v  = 32'd0;
    sz = acc_size(f3);
    for (int i = 0; i < 4; i++)
      v = v | (((r2 >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return v;
  endfunction

  int          pend;
  logic        m_rw, m_m2r;
  logic [31:0] m_alu, m_rdd;
  logic [4:0]  m_rd;
  logic        e_memop, e_mis, e_issue, e_abort, e_stall, e_err;

  always_comb begin
    e_memop = MemWriteM | MemtoRegM;
`ifdef MISALIGN_TRAP_EN
    e_mis = e_memop && ((acc_size(strCtrlM) == 2 && ALUoutM[0]) ||
                        (acc_size(strCtrlM) == 4 && ALUoutM[1:0] != 2'b00));
`else
    e_mis = 1'b0;
`endif
    e_issue = e_memop & ~e_mis;
    e_abort = e_issue & ~dmem_ready & (pend == TO - 1);
    e_stall = e_issue & ~dmem_ready & ~e_abort;
    e_err   = e_abort | (e_memop & e_mis);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 0; m_rw <= 1'b0; m_m2r <= 1'b0;
      m_alu <= 32'd0; m_rdd <= 32'd0; m_rd <= 5'd0;
    end else if (e_stall) begin
      pend <= pend + 1; m_rw <= 1'b0; m_m2r <= 1'b0;
    end else begin
      pend <= 0;
      if (e_err) begin
        m_rw <= 1'b0; m_m2r <= 1'b0;
      end else begin
        m_rw  <= RegWriteM;
        m_m2r <= MemtoRegM;
        m_alu <= ALUoutM;
        m_rd  <= rdM;
        m_rdd <= MemtoRegM ? m_load(strCtrlM, ALUoutM, dmem_rdata) : 32'd0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_stall", 32'(stallM), 0);
        chk("rst_pcsrc", 32'(PCSrcM), 0);
        chk("rst_err", 32'(bus_errM), 0);
        chk("rst_rw", 32'(RegWriteW), 0);
        chk("rst_w", {ALUoutW | ReadDataW}, 0);
      end else begin
        chk("req", 32'(dmem_req), 32'(e_issue));
        chk("stall", 32'(stallM), 32'(e_stall));
        chk("err", 32'(bus_errM), 32'(e_err));
        chk("pcsrc", 32'(PCSrcM), 32'(PCBranchM & branchM & ~e_stall));
        chk("pctarget", PCTargetM, PCplusImmM);
        if (e_issue) begin
          chk("addr", dmem_addr, ALUoutM & 32'hFFFF_FFFC);
          chk("we", 32'(dmem_we), 32'(MemWriteM));
          chk("wstrb", 32'(dmem_wstrb), MemWriteM ? 32'(m_strb(strCtrlM, ALUoutM)) : 0);
          if (MemWriteM) chk("wdata", dmem_wdata, m_wdata(strCtrlM, r2M));
        end
        chk("RegWriteW", 32'(RegWriteW), 32'(m_rw));
        chk("MemtoRegW", 32'(MemtoRegW), 32'(m_m2r));
        chk("ALUoutW", ALUoutW, m_alu);
        chk("ReadDataW", ReadDataW, m_rdd);
        chk("rdW", 32'(rdW), 32'(m_rd));
      end
    end
  endtask

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [2:0] f3, input logic rw, input logic mw, input logic mr,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] r2,
                       input logic [31:0] rdata, input logic rdy);
    strCtrlM = f3; RegWriteM = rw; MemWriteM = mw; MemtoRegM = mr;
    ALUoutM = alu; rdM = rd; r2M = r2; dmem_rdata = rdata; dmem_ready = rdy;
    PCBranchM = 1'b0; branchM = 1'b0; PCplusImmM = 32'd0;
  endtask

  task automatic nop();
    drive(3'b010, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stimulus();
    nop();
    step(); step();
    chk("reset_RegWriteW", 32'(RegWriteW), 0);
    chk("reset_dmem_req", 32'(dmem_req), 0);
    rst = 1'b1;
    step();

    // zero-wait LW
    drive(3'b010, 1, 0, 1, 32'h100, 5'd5, 0, 32'hDEADBEEF, 1);
    #1 chk("lw_stall", 32'(stallM), 0);
    step();
    chk("lw_data", ReadDataW, 32'hDEADBEEF);
    chk("lw_rw", 32'(RegWriteW), 1);
    chk("lw_rd", 32'(rdW), 5);

    // byte / half loads
    drive(3'b000, 1, 0, 1, 32'h103, 5'd6, 0, 32'h80FF_FF7F, 1);
    step(); chk("lb", ReadDataW, 32'hFFFFFF80);
    drive(3'b100, 1, 0, 1, 32'h103, 5'd6, 0, 32'h80FF_FF7F, 1);
    step(); chk("lbu", ReadDataW, 32'h00000080);
    drive(3'b001, 1, 0, 1, 32'h102, 5'd6, 0, 32'h80FF_FF7F, 1);
    step(); chk("lh", ReadDataW, 32'hFFFF80FF);
    drive(3'b101, 1, 0, 1, 32'h100, 5'd6, 0, 32'h80FF_FF7F, 1);
    step(); chk("lhu", ReadDataW, 32'h0000FF7F);

    // SB
    drive(3'b000, 0, 1, 0, 32'h201, 5'd0, 32'h12345678, 0, 1);
    #1;
    chk("sb_addr", dmem_addr, 32'h200);
    chk("sb_wstrb", 32'(dmem_wstrb), 32'b0010);
    chk("sb_wdata", dmem_wdata, 32'h78787878);
    chk("sb_we", 32'(dmem_we), 1);
    step(); chk("sb_rw", 32'(RegWriteW), 0);

    // SH aligned, then offsets that are misaligned
    drive(3'b001, 0, 1, 0, 32'h202, 5'd0, 32'hAABBCCDD, 0, 1);
    #1;
    chk("sh_wstrb", 32'(dmem_wstrb), 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'hCCDDCCDD);
    step();
    drive(3'b001, 0, 1, 0, 32'h203, 5'd0, 32'hAABBCCDD, 0, 1);
    #1;
`ifdef MISALIGN_TRAP_EN
    chk("sh3_req", 32'(dmem_req), 0);
    chk("sh3_err", 32'(bus_errM), 1);
`else
    chk("sh3_wstrb", 32'(dmem_wstrb), 32'b1100);
`endif
    step();
    drive(3'b010, 1, 0, 1, 32'h202, 5'd3, 0, 32'h01020304, 1);
    step();
`ifdef MISALIGN_TRAP_EN
    chk("lw2_rw", 32'(RegWriteW), 0);
`else
    chk("lw2_data", ReadDataW, 32'h01020304);
`endif

    // 3-wait-state load
    drive(3'b010, 1, 0, 1, 32'h300, 5'd7, 0, 32'h11223344, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("w3_stall", 32'(stallM), 1);
      step();
      chk("w3_bubble", 32'(RegWriteW), 0);
    end
    dmem_ready = 1'b1;
    #1 chk("w3_release", 32'(stallM), 0);
    step();
    chk("w3_data", ReadDataW, 32'h11223344);
    chk("w3_rw", 32'(RegWriteW), 1);

    // non-memory op; ready ignored
    drive(3'b000, 1, 0, 0, 32'hCAFE, 5'd9, 0, 32'hFFFF_FFFF, 1);
    #1 chk("alu_req", 32'(dmem_req), 0);
    step();
    chk("alu_out", ALUoutW, 32'hCAFE);
    chk("alu_rdata", ReadDataW, 0);
    chk("alu_rw", 32'(RegWriteW), 1);

    // branch
    nop(); PCBranchM = 1'b1; branchM = 1'b1; PCplusImmM = 32'h40;
    #1 chk("br_taken", 32'(PCSrcM), 1);
    chk("br_target", PCTargetM, 32'h40);
    step();
    nop(); PCBranchM = 1'b1; branchM = 1'b0; PCplusImmM = 32'h40;
    #1 chk("br_not", 32'(PCSrcM), 0);
    step();

    // timeout
    drive(3'b010, 1, 0, 1, 32'h400, 5'd8, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("to_stall", 32'(stallM), 1);
      chk("to_noerr", 32'(bus_errM), 0);
      step();
    end
    #1 chk("to_stall_end", 32'(stallM), 0);
    chk("to_err", 32'(bus_errM), 1);
    step();
    chk("to_rw", 32'(RegWriteW), 0);
    nop();
    #1 chk("to_after", 32'(bus_errM), 0);
    step();

    // reset in the middle of a wait
    drive(3'b010, 1, 0, 1, 32'h500, 5'd10, 0, 0, 0);
    step(); step();
    #1 rst = 1'b0;
    #1 chk("mid_rst_req", 32'(dmem_req), 0);
    chk("mid_rst_stall", 32'(stallM), 0);
    nop();
    step();
    #1 rst = 1'b1;
    step();
    chk("post_rst_req", 32'(dmem_req), 0);
    chk("post_rst_rw", 32'(RegWriteW), 0);
    step();
  endtask

  initial begin
    fork
      compare_loop();
      stimulus();
      begin
        repeat (5000) @(posedge clk);
        n_cmp++; n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
